// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg
// Shared types and constants for the two-requester mux arbiter.
//   state_t : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   SEL_D0  : mux select value routing d0 to the output
//   SEL_D1  : mux select value routing d1 to the output
package mux2_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;

endpackage

// File: rtl/mux2_arbiter_mux.sv
// mux_2to1
// Plain WIDTH-bit 2-to-1 data multiplexer.
// Ports:
//   sel : 0 selects a, 1 selects b
//   a   : input data 0 (WIDTH bits)
//   b   : input data 1 (WIDTH bits)
//   y   : selected data (WIDTH bits)
module mux_2to1 #(
  parameter int WIDTH = 2
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y[gi] = sel ? b[gi] : a[gi];
  end

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter
// Round-robin arbiter for two requesters sharing one WIDTH-bit output
// channel. The granted requester's data is forwarded through mux_2to1 under
// a valid/ready handshake; tenure is bounded to MAX_BURST accepted beats
// whenever the other requester is waiting.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   req0/req1  : requests from requester 0 / 1
//   d0/d1      : requester data (WIDTH bits)
//   gnt0/gnt1  : registered grants, one-hot or zero
//   sel        : registered mux select (00 -> d0, 01 -> d1)
//   out_valid  : output beat valid
//   out_data   : output beat data, zero when out_valid is low
//   out_ready  : downstream accepts the beat
//   busy       : registered, high in any grant state
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST);

  state_t          state_reg;
  logic            gnt0_reg;
  logic            gnt1_reg;
  logic [1:0]      sel_reg;
  logic            busy_reg;
  logic [CW-1:0]   beat_cnt_reg;
  logic            last_reg;

  logic [CW-1:0]   beat_cnt_next;
  logic [WIDTH-1:0] mux_y;

  // Decisions taken at the next edge
  logic go0;
  logic go1;
  logic go_idle;
  logic cnt_wrap;
  logic cnt_step;

  assign beat_cnt_next = beat_cnt_reg + 1'b1;

  // Valid follows the live request of the registered owner; out_ready only
  // feeds the state update, so there is no ready-to-output path.
  assign out_valid = (gnt0_reg & req0) | (gnt1_reg & req1);

  mux_2to1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel(sel_reg[0]),
    .a  (d0),
    .b  (d1),
    .y  (mux_y)
  );

  assign out_data = out_valid ? mux_y : '0;

  assign gnt0 = gnt0_reg;
  assign gnt1 = gnt1_reg;
  assign sel  = sel_reg;
  assign busy = busy_reg;

  // In a grant state with the owner's request high, out_valid is high, so
  // out_ready alone distinguishes an accept from a stall. A stall holds
  // everything, which is what keeps a pending beat from being switched away.
  always_comb begin
    go0      = 1'b0;
    go1      = 1'b0;
    go_idle  = 1'b0;
    cnt_wrap = 1'b0;
    cnt_step = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie, the requester that was not granted last wins.
        if (req0 && (!req1 || last_reg)) go0 = 1'b1;
        else if (req1)                   go1 = 1'b1;
      end
      GRANT0: begin
        if (!req0) begin
          if (req1) go1     = 1'b1;
          else      go_idle = 1'b1;
        end else if (out_ready) begin
          if (beat_cnt_next == BURST_LAST) begin
            if (req1) go1      = 1'b1;
            else      cnt_wrap = 1'b1;
          end else begin
            cnt_step = 1'b1;
          end
        end
      end
      GRANT1: begin
        if (!req1) begin
          if (req0) go0     = 1'b1;
          else      go_idle = 1'b1;
        end else if (out_ready) begin
          if (beat_cnt_next == BURST_LAST) begin
            if (req0) go0      = 1'b1;
            else      cnt_wrap = 1'b1;
          end else begin
            cnt_step = 1'b1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b0;
      sel_reg      <= SEL_D0;
      busy_reg     <= 1'b0;
      beat_cnt_reg <= '0;
      last_reg     <= 1'b1;
    end else if (go0) begin
      state_reg    <= GRANT0;
      gnt0_reg     <= 1'b1;
      gnt1_reg     <= 1'b0;
      sel_reg      <= SEL_D0;
      busy_reg     <= 1'b1;
      beat_cnt_reg <= '0;
      last_reg     <= 1'b0;
    end else if (go1) begin
      state_reg    <= GRANT1;
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b1;
      sel_reg      <= SEL_D1;
      busy_reg     <= 1'b1;
      beat_cnt_reg <= '0;
      last_reg     <= 1'b1;
    end else if (go_idle) begin
      // last is kept so the next tie still alternates.
      state_reg    <= IDLE;
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b0;
      sel_reg      <= SEL_D0;
      busy_reg     <= 1'b0;
      beat_cnt_reg <= '0;
    end else if (cnt_wrap) begin
      beat_cnt_reg <= '0;
    end else if (cnt_step) begin
      beat_cnt_reg <= beat_cnt_next;
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter
// Directed bench for mux2_arbiter (WIDTH=2, MAX_BURST=4). Inputs change 1ns
// after each rising edge; outputs are checked at that same point.
module tb_mux2_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0;
  logic       req1;
  logic [1:0] d0;
  logic [1:0] d1;
  logic       gnt0;
  logic       gnt1;
  logic [1:0] sel;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_ready;
  logic       busy;

  int total;
  int pass_cnt;
  int fail_cnt;

  mux2_arbiter #(
    .WIDTH    (2),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .d0       (d0),
    .d1       (d1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation {gnt0, gnt1, out_valid, out_data, busy}
  localparam logic [5:0] V_IDLE = 6'b00_0_00_0;
  localparam logic [5:0] V_G0   = 6'b10_1_11_1;  // d0 = 2'b11
  localparam logic [5:0] V_G1   = 6'b01_1_10_1;  // d1 = 2'b10

  function automatic logic [5:0] obs_vec();
    return {gnt0, gnt1, out_valid, out_data, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    total     = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    rst_n     = 1'b0;
    req0      = 1'b1;
    req1      = 1'b1;
    d0        = 2'b11;
    d1        = 2'b10;
    out_ready = 1'b1;

    // Reset held two cycles with both requests high
    tick();
    tick();
    chk("reset_outs", {26'd0, obs_vec()}, {26'd0, V_IDLE});
    chk("reset_sel",  {30'd0, sel}, 32'd0);
    chk("reset_beat", {29'd0, dut.beat_cnt_reg}, 32'd0);

    // Tie after release: requester 0 first, 4 beats each, no gaps
    rst_n = 1'b1;
    tick();
    chk("first_sel", {30'd0, sel}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_g0_%0d", k), {26'd0, obs_vec()}, {26'd0, V_G0});
      chk($sformatf("rr_g0_beat_%0d", k), {29'd0, dut.beat_cnt_reg}, k);
      tick();
    end
    chk("rr_sel1", {30'd0, sel}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_g1_%0d", k), {26'd0, obs_vec()}, {26'd0, V_G1});
      chk($sformatf("rr_g1_beat_%0d", k), {29'd0, dut.beat_cnt_reg}, k);
      tick();
    end
    chk("rr_back_g0", {26'd0, obs_vec()}, {26'd0, V_G0});
    chk("rr_back_beat", {29'd0, dut.beat_cnt_reg}, 32'd0);

    // Stall on the 4th beat of GRANT0 while requester 1 waits
    tick();
    tick();
    tick();
    chk("stall_pre_beat", {29'd0, dut.beat_cnt_reg}, 32'd3);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_hold_%0d", k), {26'd0, obs_vec()}, {26'd0, V_G0});
      chk($sformatf("stall_sel_%0d", k), {30'd0, sel}, 32'd0);
      chk($sformatf("stall_beat_%0d", k), {29'd0, dut.beat_cnt_reg}, 32'd3);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_switch", {26'd0, obs_vec()}, {26'd0, V_G1});
    chk("stall_switch_sel", {30'd0, sel}, 32'd1);

    // Both requests fall together: back to IDLE
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("both_fall_idle", {26'd0, obs_vec()}, {26'd0, V_IDLE});

    // Single requester, then out_data forced to zero once req0 drops
    req0 = 1'b1;
    tick();
    chk("single_g0", {26'd0, obs_vec()}, {26'd0, V_G0});
    req0 = 1'b0;
    #1;
    chk("single_drop_comb", {26'd0, obs_vec()}, {26'd0, 6'b10_0_00_1});
    tick();
    chk("single_release", {26'd0, obs_vec()}, {26'd0, V_IDLE});

    // Uncontested burst: 10 accepted beats, counter wraps every 4th
    req0 = 1'b1;
    tick();
    chk("unc_entry_beat", {29'd0, dut.beat_cnt_reg}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("unc_g0_%0d", i), {26'd0, obs_vec()}, {26'd0, V_G0});
      chk($sformatf("unc_beat_%0d", i), {29'd0, dut.beat_cnt_reg}, i % 4);
    end

    // req0 falls as req1 rises: direct handover
    req0 = 1'b0;
    req1 = 1'b1;
    tick();
    chk("handover_g1", {26'd0, obs_vec()}, {26'd0, V_G1});
    chk("handover_beat", {29'd0, dut.beat_cnt_reg}, 32'd0);

    // Reset during GRANT1 beat 2
    tick();
    tick();
    chk("mid_beat2", {29'd0, dut.beat_cnt_reg}, 32'd2);
    rst_n = 1'b0;
    req0  = 1'b1;
    tick();
    chk("mid_reset_outs", {26'd0, obs_vec()}, {26'd0, V_IDLE});
    chk("mid_reset_sel", {30'd0, sel}, 32'd0);
    chk("mid_reset_beat", {29'd0, dut.beat_cnt_reg}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_g0", {26'd0, obs_vec()}, {26'd0, V_G0});
    chk("post_reset_sel", {30'd0, sel}, 32'd0);

    // Only req1 from IDLE
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("idle_again", {26'd0, obs_vec()}, {26'd0, V_IDLE});
    req1 = 1'b1;
    tick();
    chk("only_req1_g1", {26'd0, obs_vec()}, {26'd0, V_G1});
    chk("only_req1_sel", {30'd0, sel}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
